// File: rtl/rf_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_seq_pkg
// Purpose  : Shared opcode/state encodings and default widths for rf_seq.
// Revision : 1.0  initial release
// ============================================================================
package rf_seq_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    function automatic logic is_alu_op(input op_e op);
        return (op != OP_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : rf_seq_alu
// Purpose  : Combinational ADD/SUB/AND with carry (ADD) or borrow (SUB) out.
// Revision : 1.0  initial release
// ============================================================================
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              c
);

    logic [DATA_W:0] w_ext;

    // One extra bit: its MSB is the ADD carry, or the SUB borrow (a < b).
    always_comb begin
        w_ext = '0;
        case (op)
            OP_ADD:  w_ext = {1'b0, a} + {1'b0, b};
            OP_SUB:  w_ext = {1'b0, a} - {1'b0, b};
            OP_AND:  w_ext = {1'b0, a & b};
            default: w_ext = '0;
        endcase
    end

    assign r = w_ext[DATA_W-1:0];
    assign c = w_ext[DATA_W];

endmodule
`default_nettype wire

// File: rtl/rf_seq.sv
`default_nettype none
// ============================================================================
// Module   : rf_seq
// Purpose  : Register-file operation sequencer: accepts one instruction per
//            handshake, reads operands, computes and writes the result back.
// Revision : 1.0  initial release
// ============================================================================
module rf_seq
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic [ADDR_W-1:0] instr_srca,
    input  logic [ADDR_W-1:0] instr_srcb,
    input  logic [DATA_W-1:0] instr_imm,
    output logic              rea,
    output logic              reb,
    output logic [ADDR_W-1:0] raa,
    output logic [ADDR_W-1:0] rab,
    input  logic [DATA_W-1:0] douta,
    input  logic [DATA_W-1:0] doutb,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] din,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    logic [1:0]        r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_raa;
    logic [ADDR_W-1:0] r_rab;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic              r_carry;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_c;

    logic              w_accept;
    op_e               w_op_in;
    logic [DATA_W-1:0] w_alu_r;
    logic              w_alu_c;

    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_op_in  = op_e'(instr_op);

    rf_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op (r_op),
        .a  (r_opa),
        .b  (r_opb),
        .r  (w_alu_r),
        .c  (w_alu_c)
    );

    // Address/data registers are only loaded on the path into the state that
    // drives them, so they hold their last value whenever not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_LOAD;
            r_dst    <= '0;
            r_raa    <= '0;
            r_rab    <= '0;
            r_wa     <= '0;
            r_din    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op_in;
                        r_dst <= instr_dst;
                        if (is_alu_op(w_op_in)) begin
                            r_raa   <= instr_srca;
                            r_rab   <= instr_srcb;
                            r_state <= ST_READ;
                        end else begin
                            r_wa    <= instr_dst;
                            r_din   <= instr_imm;
                            r_carry <= 1'b0;
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    r_opa   <= douta;
                    r_opb   <= doutb;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_din   <= w_alu_r;
                    r_carry <= w_alu_c;
                    r_wa    <= r_dst;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_result <= r_din;
                    r_flag_z <= (r_din == '0);
                    r_flag_c <= r_carry;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign rea         = (r_state == ST_READ);
    assign reb         = (r_state == ST_READ);
    assign we          = (r_state == ST_WRITE);
    assign done        = (r_state == ST_WRITE);
    assign raa         = r_raa;
    assign rab         = r_rab;
    assign wa          = r_wa;
    assign din         = r_din;
    assign result      = r_result;
    assign flag_z      = r_flag_z;
    assign flag_c      = r_flag_c;

endmodule
`default_nettype wire

// File: tb/tb_rf_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_seq
// Purpose  : Self-checking bench for rf_seq with a behavioural register file.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_seq;

    localparam int DW = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_op;
    logic [AW-1:0] instr_dst, instr_srca, instr_srcb;
    logic [DW-1:0] instr_imm;
    logic          rea, reb, we, done, flag_z, flag_c;
    logic [AW-1:0] raa, rab, wa;
    logic [DW-1:0] douta, doutb, din, result;

    always #5 clk = ~clk;

    rf_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_dst   (instr_dst),
        .instr_srca  (instr_srca),
        .instr_srcb  (instr_srcb),
        .instr_imm   (instr_imm),
        .rea         (rea),
        .reb         (reb),
        .raa         (raa),
        .rab         (rab),
        .douta       (douta),
        .doutb       (doutb),
        .we          (we),
        .wa          (wa),
        .din         (din),
        .done        (done),
        .result      (result),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    // Register-file responder: combinational reads, write on the rising edge.
    logic [DW-1:0] rf [4];
    always @(posedge clk) if (we) rf[wa] <= din;
    assign douta = rf[raa];
    assign doutb = rf[rab];

    int tests = 0;
    int fails = 0;
    int ref_rf [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    task automatic model(input int op, input int a, input int b, input int imm,
                         output int r, output int c);
        int s;
        case (op)
            0: begin r = imm; c = 0; end
            1: begin s = a + b; r = s % 16; c = (s >= 16) ? 1 : 0; end
            2: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            default: begin r = a & b; c = 0; end
        endcase
    endtask

    task automatic scramble();
        instr_op   = 2'($urandom);
        instr_dst  = 2'($urandom);
        instr_srca = 2'($urandom);
        instr_srcb = 2'($urandom);
        instr_imm  = 4'($urandom);
    endtask

    task automatic do_instr(input int op, input int dst, input int sa, input int sb,
                            input int imm, input bit garbage, input bit chain);
        int r, c, cyc, lat;
        model(op, ref_rf[sa], ref_rf[sb], imm, r, c);
        lat = (op == 0) ? 1 : 3;
        instr_valid = 1'b1;
        instr_op    = op[1:0];
        instr_dst   = dst[AW-1:0];
        instr_srca  = sa[AW-1:0];
        instr_srcb  = sb[AW-1:0];
        instr_imm   = imm[DW-1:0];
        cyc = 0;
        while (!instr_ready && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_idle", 32'(instr_ready), 1);
        chk("quiet_idle", 32'({rea, reb, we, done}), 0);
        @(posedge clk);
        #1;
        if (garbage) scramble();
        else instr_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            chk("ready_busy", 32'(instr_ready), 0);
            if (op != 0 && cyc == 1) begin
                chk("read_en", 32'({rea, reb, we}), 32'h6);
                chk("raa", 32'(raa), sa);
                chk("rab", 32'(rab), sb);
            end
            if (op != 0 && cyc == 2) chk("exec_quiet", 32'({rea, reb, we, done}), 0);
            if (garbage) scramble();
        end while (!done && cyc < 8);
        chk("latency", cyc, lat);
        chk("we_write", 32'(we), 1);
        chk("wa", 32'(wa), dst);
        chk("din", 32'(din), r);
        chk("rd_off_write", 32'({rea, reb}), 0);
        ref_rf[dst] = r;
        if (!chain) begin
            instr_valid = 1'b0;
            @(negedge clk);
            chk("result", 32'(result), r);
            chk("flag_z", 32'(flag_z), (r == 0) ? 1 : 0);
            chk("flag_c", 32'(flag_c), c);
            chk("rf_dst", 32'(rf[dst]), r);
            chk("post_quiet", 32'({rea, reb, we, done, instr_ready}), 1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_dst   = '0;
        instr_srca  = '0;
        instr_srcb  = '0;
        instr_imm   = '0;
        for (int i = 0; i < 4; i++) ref_rf[i] = 0;
        #12;
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_ctrl", 32'({rea, reb, we, done}), 0);
        chk("rst_addr", 32'({raa, rab, wa}), 0);
        chk("rst_din", 32'(din), 0);
        chk("rst_state", 32'({result, flag_z, flag_c}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence
        do_instr(0, 2, 0, 0, 10, 0, 0);
        do_instr(0, 0, 0, 0, 9, 0, 0);
        do_instr(0, 1, 0, 0, 8, 0, 0);
        do_instr(1, 3, 0, 1, 0, 0, 0);
        do_instr(2, 0, 1, 1, 0, 0, 0);
        do_instr(2, 3, 0, 1, 0, 0, 0);
        do_instr(1, 1, 1, 1, 0, 0, 1);
        do_instr(3, 2, 1, 1, 0, 0, 0);
        do_instr(1, 3, 2, 0, 0, 1, 0);
        do_instr(0, 0, 3, 1, 5, 1, 0);

        // Reset during EXEC of an ADD targeting R2
        instr_valid = 1'b1;
        instr_op    = 2'b01;
        instr_dst   = 2'd2;
        instr_srca  = 2'd0;
        instr_srcb  = 2'd0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 32'({we, done, rea, reb}), 0);
        chk("abort_ready", 32'(instr_ready), 1);
        chk("abort_state", 32'({result, flag_z, flag_c}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_write", 32'({we, done}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_rf_kept", 32'(rf[2]), ref_rf[2]);

        // Randomized phase: seed every register, then mixed traffic
        for (int i = 0; i < 4; i++) do_instr(0, i, 0, 0, int'($urandom_range(15)), 0, 0);
        for (int n = 0; n < 40; n++) begin
            do_instr(int'($urandom_range(3)), int'($urandom_range(3)),
                     int'($urandom_range(3)), int'($urandom_range(3)),
                     int'($urandom_range(15)), 1'($urandom), (n != 39) ? 1'($urandom) : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_seq.md
Name: rf_seq

Overview:
Operation sequencer that is the initiator side of the 4x4 register-file port set: it generates the read enables/addresses, consumes the two read data buses, and generates the write enable/address/data.
It accepts one register-transfer instruction per valid/ready handshake, reads operands, computes a 4-bit result and writes it back.
Sits between the instruction source (lab top / switch logic) and the register file in the lab datapath.

Parameters:
DATA_W, 4, register/data width (result arithmetic is modulo 2^DATA_W)
ADDR_W, 2, register address width (2^ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on instr_* fields
instr_ready  output  1  sequencer can accept an instruction
instr_op  input  2  00 LOAD imm, 01 ADD, 10 SUB, 11 AND
instr_dst  input  ADDR_W  destination register
instr_srca  input  ADDR_W  operand A register
instr_srcb  input  ADDR_W  operand B register
instr_imm  input  DATA_W  immediate (LOAD only)
rea  output  1  read enable, port A
reb  output  1  read enable, port B
raa  output  ADDR_W  read address, port A
rab  output  ADDR_W  read address, port B
douta  input  DATA_W  read data A (combinational from RF)
doutb  input  DATA_W  read data B (combinational from RF)
we  output  1  write enable
wa  output  ADDR_W  write address
din  output  DATA_W  write data
done  output  1  one-cycle pulse, write commits at the next rising edge
result  output  DATA_W  last written value (held)
flag_z  output  1  last result == 0 (held)
flag_c  output  1  ADD carry-out / SUB borrow (result < 0); 0 for LOAD/AND (held)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, instruction latch cleared, operand regs 0, result/flag_z/flag_c 0, rea/reb/we/done 0, raa/rab/wa/din 0. instr_ready=1 while in IDLE, including during reset.
- States: IDLE, READ, EXEC, WRITE. All RF control outputs are decoded from the registered state and latched fields only, never from instr_* directly.
- IDLE: instr_ready=1. On instr_valid&&instr_ready at a rising edge, latch op/dst/srca/srcb/imm. Next state READ, or WRITE if op==LOAD.
- READ (1 cycle): rea=reb=1, raa=srca, rab=srcb. At the end-of-cycle edge, capture douta->opA and doutb->opB. Next state EXEC.
- EXEC (1 cycle): compute into res_reg with DATA_W+1-bit arithmetic.
  - ADD: {c,r}=opA+opB.
  - SUB: {b,r}=opA-opB; b=1 iff opA<opB unsigned.
  - AND: r=opA&opB, c=0.
  - Next state WRITE.
- WRITE (1 cycle): we=1, wa=dst, din=res_reg (LOAD: din=imm). done=1. At the end-of-cycle edge: result<=din, flag_z<=(din==0), flag_c<=carry (0 for LOAD/AND). Next state IDLE.
- Latency, acceptance edge to done: LOAD 1 cycle, ALU op 3 cycles. Throughput: 2 cycles per LOAD, 4 cycles per ALU op. instr_ready=0 in READ/EXEC/WRITE.
- rea/reb/we are 0 outside READ/WRITE. raa/rab/wa/din hold their last values when not enabled.
- srca==srcb is legal; both ports read the same register.
- dst equal to a source is legal: the read completes before the write.
- Back-to-back dependent instructions need no forwarding: the write commits at the edge that returns to IDLE, so the next READ sees it.
- instr_* changes while instr_ready=0 are ignored.
- rst_n asserted mid-operation aborts immediately: state IDLE, we=0 asynchronously, no write is issued. Outputs are not required to restore RF contents.
- rst_n deassertion is assumed synchronised externally.

Decomposition:
- Shared package: op encodings (OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_AND=2'b11), state encodings, DATA_W/ADDR_W defaults.
- One natural sub-module: rf_seq_alu, combinational (op, a, b -> r, c), instantiated for EXEC.
- The bench instantiates the existing register file as the responder.

Test Plan:
- Reset then LOAD dst=2 imm=4'hA -> instr_ready=0 for 1 cycle; we=1, wa=2, din=A with done=1 in the WRITE cycle; result=A, flag_z=0, flag_c=0; RF[2]=A.
- LOAD R0=9, LOAD R1=8, then ADD dst=3 srca=0 srcb=1 -> READ cycle shows rea=reb=1, raa=0, rab=1; done 3 cycles after acceptance; din=4'h1, flag_c=1, flag_z=0.
- SUB dst=0 srca=1 srcb=1 (R1=8) -> din=0, flag_z=1, flag_c=0. Then SUB R0-R1 with R0=0 -> din=4'h8, flag_c=1.
- Dependent pair: ADD dst=1 srca=1 srcb=1, immediately followed by AND dst=2 srca=1 srcb=1 -> the AND reads the updated R1 with no stall beyond the handshake; instr_valid held high is accepted only when instr_ready=1.
- Reset asserted during EXEC of an ADD -> we never rises, done never pulses, instr_ready=1 immediately, result/flags return to 0.
- instr_valid held high with changing fields while busy -> only the fields present at the acceptance edge are executed; rea/reb/we are 0 in IDLE.
